// File: rtl/phase_sequencer.sv
// Phase sequencer for the multi-cycle RV32I core: one-hot phase enables, MMIO wait states,
// run/pause/step control and terminal halt. Define SEQ_PERF_COUNTERS_EN for retired/active-cycle counters.
//
// state   | meaning
// S_PAUSE | idle at an instruction boundary, phase_o = 0
// S_RUN   | stepping through phases 0..NUM_PHASES-1
// S_WAIT  | held in the data phase until mem_ready_i or timeout
// S_HALT  | terminal trap, only rst leaves
module phase_sequencer #(
   parameter int NUM_PHASES = 4,
   parameter int MAX_WAIT   = 15,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_i,
   input  logic                  step_i,
   input  logic                  halt_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ready_i,
   output logic [NUM_PHASES-1:0] phase_o,
   output logic                  fetch_o,
   output logic                  data_o,
   output logic                  compute_o,
   output logic                  writeback_o,
   output logic                  stalled_o,
   output logic                  paused_o,
   output logic                  halted_o,
   output logic                  timeout_o,
   output logic [CNT_W-1:0]      retired_o,
   output logic [CNT_W-1:0]      cycles_o
);

   localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [PW-1:0] PH_DATA  = PW'(1);
   localparam logic [PW-1:0] PH_COMP  = PW'(2);
   localparam logic [PW-1:0] PH_LAST  = PW'(NUM_PHASES - 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   typedef enum logic [1:0] {S_PAUSE, S_RUN, S_WAIT, S_HALT} state_t;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_phase, w_phase_nxt;
   logic [WW-1:0] r_wait, w_wait_nxt;
   logic          r_oneshot, w_oneshot_nxt;
   logic          r_timeout, w_timeout_nxt;
   logic          w_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_PAUSE;
         r_phase   <= '0;
         r_wait    <= '0;
         r_oneshot <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_wait    <= w_wait_nxt;
         r_oneshot <= w_oneshot_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_phase_nxt   = r_phase;
      w_wait_nxt    = r_wait;
      w_oneshot_nxt = r_oneshot;
      w_timeout_nxt = r_timeout;
      case (r_state)
         S_PAUSE: begin
            if (run_i || step_i) begin
               w_state_nxt   = S_RUN;
               w_phase_nxt   = '0;
               w_oneshot_nxt = step_i;
            end
         end
         S_RUN: begin
            if (r_phase == PH_DATA && mem_req_i && !mem_ready_i) begin
               // wait counter counts stall cycles including the first
               w_state_nxt = S_WAIT;
               w_wait_nxt  = WW'(1);
            end else if (r_phase == PH_LAST) begin
               if (halt_i) begin
                  w_state_nxt = S_HALT;
               end else if (!run_i || r_oneshot) begin
                  w_state_nxt   = S_PAUSE;
                  w_oneshot_nxt = 1'b0;
               end else begin
                  w_phase_nxt = '0;
               end
            end else begin
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_ready_i || r_wait == WAIT_MAX) begin
               w_state_nxt = S_RUN;
               w_phase_nxt = PH_COMP;
               w_wait_nxt  = '0;
               if (!mem_ready_i) w_timeout_nxt = 1'b1;
            end else begin
               w_wait_nxt = r_wait + 1'b1;
            end
         end
         S_HALT: begin
         end
         default: w_state_nxt = S_PAUSE;
      endcase
   end

   assign w_active    = (r_state == S_RUN) || (r_state == S_WAIT);
   assign phase_o     = w_active ? (NUM_PHASES'(1) << r_phase) : '0;
   assign fetch_o     = w_active && (r_phase == '0);
   assign data_o      = w_active && (r_phase == PH_DATA);
   assign compute_o   = w_active && (r_phase >= PH_COMP) && (r_phase < PH_LAST);
   assign writeback_o = w_active && (r_phase == PH_LAST);
   assign stalled_o   = (r_state == S_WAIT);
   assign paused_o    = (r_state == S_PAUSE);
   assign halted_o    = (r_state == S_HALT);
   assign timeout_o   = r_timeout;

`ifdef SEQ_PERF_COUNTERS_EN
   logic [CNT_W-1:0] r_retired, r_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= '0;
         r_cycles  <= '0;
      end else begin
         if (r_state == S_RUN && r_phase == PH_LAST) r_retired <= r_retired + 1'b1;
         if (w_active) r_cycles <= r_cycles + 1'b1;
      end
   end

   assign retired_o = r_retired;
   assign cycles_o  = r_cycles;
`else
   assign retired_o = '0;
   assign cycles_o  = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios then randomized traffic,
// all checked cycle by cycle against an instruction-level reference model.
module tb_phase_sequencer;
   localparam int NP = 4;
   localparam int MW = 3;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst, run_i, step_i, halt_i, mem_req_i, mem_ready_i;
   logic [NP-1:0] phase_o;
   logic          fetch_o, data_o, compute_o, writeback_o;
   logic          stalled_o, paused_o, halted_o, timeout_o;
   logic [CW-1:0] retired_o, cycles_o;

   phase_sequencer #(.NUM_PHASES(NP), .MAX_WAIT(MW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
      .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i), .phase_o(phase_o),
      .fetch_o(fetch_o), .data_o(data_o), .compute_o(compute_o),
      .writeback_o(writeback_o), .stalled_o(stalled_o), .paused_o(paused_o),
      .halted_o(halted_o), .timeout_o(timeout_o), .retired_o(retired_o),
      .cycles_o(cycles_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_stall, n_act, n_wb;

   // model: mode 0 paused, 1 running, 2 waiting, 3 halted
   int          m_mode, m_ph, m_waited;
   bit          m_single, m_to;
   logic [31:0] m_ret, m_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_mode = 0; m_ph = 0; m_waited = 0; m_single = 0; m_to = 0;
         m_ret = 0; m_cyc = 0;
         return;
      end
      if (m_mode == 1 || m_mode == 2) m_cyc++;
      if (m_mode == 0) begin
         if (run_i || step_i) begin
            m_mode = 1; m_ph = 0; m_single = step_i;
         end
      end else if (m_mode == 1) begin
         if (m_ph == 1 && mem_req_i && !mem_ready_i) begin
            m_mode = 2; m_waited = 1;
         end else if (m_ph == NP - 1) begin
            m_ret++;
            if (halt_i) m_mode = 3;
            else if (!run_i || m_single) begin m_mode = 0; m_single = 0; end
            else m_ph = 0;
         end else begin
            m_ph++;
         end
      end else if (m_mode == 2) begin
         if (mem_ready_i) begin
            m_mode = 1; m_ph = 2; m_waited = 0;
         end else if (m_waited >= MW) begin
            m_mode = 1; m_ph = 2; m_waited = 0; m_to = 1;
         end else begin
            m_waited++;
         end
      end
   endtask

   task automatic check_all();
      bit act;
      act = (m_mode == 1 || m_mode == 2);
      chk("phase",     phase_o,     act ? (32'd1 << m_ph) : 32'd0);
      chk("fetch",     fetch_o,     act && m_ph == 0);
      chk("data",      data_o,      act && m_ph == 1);
      chk("compute",   compute_o,   act && m_ph >= 2 && m_ph <= NP - 2);
      chk("writeback", writeback_o, act && m_ph == NP - 1);
      chk("stalled",   stalled_o,   m_mode == 2);
      chk("paused",    paused_o,    m_mode == 0);
      chk("halted",    halted_o,    m_mode == 3);
      chk("timeout",   timeout_o,   m_to);
`ifdef SEQ_PERF_COUNTERS_EN
      chk("retired",   retired_o,   m_ret);
      chk("cycles",    cycles_o,    m_cyc);
`else
      chk("retired",   retired_o,   32'd0);
      chk("cycles",    cycles_o,    32'd0);
`endif
   endtask

   task automatic cyc(input logic r, input logic run, input logic st, input logic h,
                      input logic req, input logic rdy);
      rst = r; run_i = run; step_i = st; halt_i = h; mem_req_i = req; mem_ready_i = rdy;
      @(posedge clk);
      model_step();
      #1;
      check_all();
      n_stall += int'(stalled_o);
      n_act   += int'(|phase_o);
      n_wb    += int'(writeback_o);
   endtask

   task automatic clr_stats();
      n_stall = 0; n_act = 0; n_wb = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_stats();
      m_mode = 0; m_ph = 0; m_waited = 0; m_single = 0; m_to = 0; m_ret = 0; m_cyc = 0;

      // free-run
      cyc(1, 0, 0, 0, 0, 0);
      clr_stats();
      repeat (13) cyc(0, 1, 0, 0, 0, 0);
      chk("t1_wb_count", n_wb, 3);
`ifdef SEQ_PERF_COUNTERS_EN
      chk("t1_retired", retired_o, 3);
      chk("t1_cycles", cycles_o, 12);
`endif

      // wait state released by ready after two stall cycles
      cyc(1, 0, 0, 0, 0, 0);
      clr_stats();
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      repeat (5) cyc(0, 0, 0, 0, 1, 1);
      chk("t2_stall_cycles", n_stall, 2);
      chk("t2_active_cycles", n_act, 6);
      chk("t2_timeout", timeout_o, 0);

      // timeout
      cyc(1, 0, 0, 0, 0, 0);
      clr_stats();
      cyc(0, 0, 1, 0, 1, 0);
      repeat (11) cyc(0, 0, 0, 0, 1, 0);
      chk("t3_stall_cycles", n_stall, 3);
      chk("t3_active_cycles", n_act, 7);
      chk("t3_timeout", timeout_o, 1);
      repeat (6) cyc(0, 1, 0, 0, 0, 1);
      chk("t3_timeout_sticky", timeout_o, 1);

      // single step with a second ignored step pulse
      cyc(1, 0, 0, 0, 0, 0);
      clr_stats();
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      repeat (7) cyc(0, 0, 0, 0, 0, 0);
      chk("t4_active_cycles", n_act, 4);
      chk("t4_paused", paused_o, 1);
`ifdef SEQ_PERF_COUNTERS_EN
      chk("t4_retired", retired_o, 1);
`endif

      // halt is terminal
      cyc(1, 0, 0, 0, 0, 0);
      repeat (6) cyc(0, 1, 0, 1, 0, 0);
      chk("t5_halted", halted_o, 1);
      clr_stats();
      repeat (20) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("t5_halt_active", n_act, 0);
      chk("t5_halted_after", halted_o, 1);
      cyc(1, 0, 0, 0, 0, 0);
      chk("t5_rst_clears", halted_o, 0);

      // reset while stalled
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t6_in_wait", stalled_o, 1);
      cyc(1, 1, 0, 0, 1, 0);
      chk("t6_stalled", stalled_o, 0);
      chk("t6_paused", paused_o, 1);
      chk("t6_phase", phase_o, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 39) == 0),
             1'($urandom),
             ($urandom_range(0, 2) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Parametrised successor to the core's fixed 2-bit phase counter: generates the one-hot phase enables (fetch, data read, compute, write-back) for the multi-cycle RV32I core.
- Adds a configurable phase count and MMIO wait-state insertion via a ready handshake with a bounded timeout.
- Adds run/pause/single-step control, a terminal halt (pass/fail trap), and optional retired-instruction and active-cycle counters.
- Sits between the top-level control inputs (button, debug) and the core datapath's register-file, data-memory, UART and PC-update enables.

## Interface
Parameters:
- NUM_PHASES, 4, phases per instruction; legal ≥ 3. Phase 0 = fetch, 1 = data read, 2..NUM_PHASES-2 = compute, NUM_PHASES-1 = write-back.
- MAX_WAIT, 15, maximum wait cycles in the data phase before timeout; legal ≥ 1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- run_i  in  1  level; 1 = free-run, 0 = pause at the next instruction boundary.
- step_i  in  1  one-cycle pulse; runs exactly one instruction while paused.
- halt_i  in  1  trap request (pass/fail PC hit); sampled only in write-back.
- mem_req_i  in  1  current instruction accesses data memory or MMIO.
- mem_ready_i  in  1  target has data valid.
- phase_o  out  NUM_PHASES  one-hot phase; all-zero when not running.
- fetch_o, data_o, compute_o, writeback_o  out  1 each  decoded phase strobes; compute_o covers all compute phases.
- stalled_o  out  1  holding in the data phase awaiting mem_ready_i.
- paused_o  out  1  in PAUSE.
- halted_o  out  1  in HALT (terminal).
- timeout_o  out  1  sticky; set on any wait timeout.
- retired_o  out  CNT_W  instructions completed.
- cycles_o  out  CNT_W  cycles with phase_o ≠ 0.

## Operation
- States: PAUSE, RUN, WAIT, HALT. Phase index is registered; all outputs are driven directly from state registers (no combinational path from inputs to outputs).
- Reset: state = PAUSE; phase_o = 0; all strobes = 0; stalled_o = 0; halted_o = 0; timeout_o = 0; counters = 0; paused_o = 1.
- PAUSE → RUN at phase 0 when run_i = 1 or step_i = 1. A step pulse arms a one-shot flag.
- RUN: phase increments by 1 each cycle.
- Data phase with mem_req_i = 1 and mem_ready_i = 0 → WAIT. Phase is held, stalled_o = 1, and the wait counter increments each cycle.
- WAIT → RUN, advancing to phase 2, on mem_ready_i = 1.
- WAIT timeout: when the wait counter reaches MAX_WAIT, advance anyway and set timeout_o. The wait counter clears on every exit from WAIT.
- mem_req_i = 0 in the data phase: no wait is inserted.
- Write-back phase (final cycle of every instruction):
  - retired increments.
  - halt_i = 1 → HALT.
  - else run_i = 0 or one-shot armed → PAUSE (one-shot cleared).
  - else wrap to phase 0.
- HALT: phase_o = 0 and halted_o = 1. Only rst exits HALT; run_i and step_i are ignored.
- Simultaneous events:
  - step_i while in RUN: ignored.
  - run_i falling mid-instruction: the current instruction completes.
  - halt_i and run_i = 0 together in write-back: HALT wins.
  - rst in any state or phase, including WAIT: return to reset values next cycle.
- Counters wrap modulo 2^CNT_W. cycles_o increments on every cycle with phase_o ≠ 0, including WAIT cycles.

## Timing
- run_i or step_i sampled high in PAUSE → fetch_o = 1 on the next cycle (latency 1).
- Unstalled instruction: exactly NUM_PHASES cycles; writeback_o is high for exactly 1 cycle per instruction.
- Stalled instruction: NUM_PHASES + w cycles, w ≤ MAX_WAIT.
- mem_ready_i sampled during the data phase or WAIT → phase 2 on the next cycle.
- retired_o updates on the cycle after write-back.
- paused_o / halted_o assert on the cycle after write-back.

## Configuration
- SEQ_PERF_COUNTERS_EN defined: retired_o and cycles_o counters are implemented as described.
- SEQ_PERF_COUNTERS_EN undefined: no counter registers exist; retired_o and cycles_o are tied to 0. All other behaviour is identical.

## Test plan
All scenarios use NUM_PHASES = 4, MAX_WAIT = 3, and SEQ_PERF_COUNTERS_EN defined.
1. Free-run: rst, then run_i = 1, mem_req_i = 0 for 12 cycles → writeback_o pulses at cycles 4, 8, 12; retired_o = 3; cycles_o = 12.
2. Wait state: mem_req_i = 1, mem_ready_i rises 2 cycles after data phase entry → stalled_o high for 2 cycles; instruction takes 6 cycles; timeout_o = 0.
3. Timeout: mem_req_i = 1, mem_ready_i = 0 throughout → stalled_o high for 3 cycles, then compute; timeout_o = 1 and remains 1 afterwards.
4. Single-step: run_i = 0, one step_i pulse → exactly 4 active cycles, then paused_o = 1 and retired_o = 1. A second step_i pulse issued during the step is ignored.
5. Halt: halt_i = 1 during write-back → halted_o = 1 and phase_o = 0. Toggling run_i and step_i for 20 cycles has no effect; rst clears it.
6. Reset during WAIT: assert rst while stalled → next cycle all outputs are at reset values and counters = 0.
